cacheline_arb_adapter: RTL and testbench

Parametrised, multi-port successor to the single-port line adapter: it arbitrates between NUM_PORTS cache clients (e.g. I-cache, D-cache) and serialises each granted line read or write into BEATS = LINE_W/BEAT_W bursts on the single burst-memory port. It sits between the cache hierarchy and burst memory, returns a full line plus its aligned address, and pulses a one-hot per-port response.

---
 rtl/cacheline_arb_pkg.sv | 23 ++
 rtl/cacheline_rr_arbiter.sv | 62 ++++++
 rtl/cacheline_arb_adapter.sv | 163 ++++++++++++++++
 tb/tb_cacheline_arb_adapter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cacheline_arb_pkg.sv
// Shared types for the multi-port cache-line adapter: FSM states, the
// latched operation encoding and the line-offset helper.
package cacheline_arb_pkg;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      READ_REQ    = 3'd1,
      READ_BURST  = 3'd2,
      WRITE_BURST = 3'd3,
      RESP        = 3'd4
   } state_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_t;

   // Number of byte-offset bits inside one cache line.
   function automatic int offset_bits(input int line_w);
      return $clog2(line_w / 8);
   endfunction

endpackage

// File: rtl/cacheline_rr_arbiter.sv
// Request arbiter for the cache-line adapter.
// With CACHELINE_ARB_RR_EN defined the search rotates from the port after
// the last grant; otherwise the lowest requesting index wins and no pointer
// register exists.
module cacheline_rr_arbiter #(
   parameter int NUM_PORTS = 2,
   parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [NUM_PORTS-1:0] req,
   output logic [NUM_PORTS-1:0] grant,
   output logic [IDX_W-1:0]     grant_idx,
   output logic                 grant_valid
);

`ifdef CACHELINE_ARB_RR_EN
   logic [IDX_W-1:0] ptr;
   int               rr_idx;

   // Rotating search; scanning offsets downward leaves the nearest port after ptr as winner.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      rr_idx      = 0;
      for (int i = NUM_PORTS; i >= 1; i--) begin
         rr_idx = (int'(ptr) + i) % NUM_PORTS;
         if (req[rr_idx]) begin
            grant_idx   = IDX_W'(rr_idx);
            grant_valid = 1'b1;
         end
      end
      if (grant_valid) grant[grant_idx] = 1'b1;
   end

   // Pointer holds the last granted port; reset value makes port 0 first in line.
   always_ff @(posedge clk) begin
      if (rst)                      ptr <= IDX_W'(NUM_PORTS - 1);
      else if (en && grant_valid)   ptr <= grant_idx;
   end
`else
   logic unused_rr;
   assign unused_rr = ^{clk, rst, en};

   // Fixed priority: scanning downward leaves the lowest requesting index as winner.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant_idx   = IDX_W'(i);
            grant_valid = 1'b1;
         end
      end
      if (grant_valid) grant[grant_idx] = 1'b1;
   end
`endif

endmodule

// File: rtl/cacheline_arb_adapter.sv
// Multi-port cache-line adapter: arbitrates NUM_PORTS cache clients and
// serialises each granted line read/write into BEATS beats on one burst
// memory port. Optional feature macro: CACHELINE_ARB_RR_EN (round-robin
// arbitration instead of fixed lowest-index priority).
//
// Memory handshake: a command (bmem_read) or write beat (bmem_write) is
// transferred on a rising edge where it is asserted together with
// bmem_ready; the adapter holds address/data stable until then. Read beats
// have no back-pressure: each bmem_rvalid in READ_BURST tagged with the
// latched line address is consumed, any other beat is dropped.
module cacheline_arb_adapter
   import cacheline_arb_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 32,
   parameter int LINE_W    = 256,
   parameter int BEAT_W    = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_PORTS*ADDR_W-1:0] cache_addr,
   input  logic [NUM_PORTS-1:0]        cache_read,
   input  logic [NUM_PORTS-1:0]        cache_write,
   input  logic [NUM_PORTS*LINE_W-1:0] cache_wdata,
   output logic [LINE_W-1:0]           cache_rdata,
   output logic [ADDR_W-1:0]           cache_raddr,
   output logic [NUM_PORTS-1:0]        cache_resp,
   output logic [ADDR_W-1:0]           bmem_addr,
   output logic                        bmem_read,
   output logic                        bmem_write,
   output logic [BEAT_W-1:0]           bmem_wdata,
   input  logic                        bmem_ready,
   input  logic [BEAT_W-1:0]           bmem_rdata,
   input  logic [ADDR_W-1:0]           bmem_raddr,
   input  logic                        bmem_rvalid,
   output state_t                      dbg_state
);

   localparam int BEATS = LINE_W / BEAT_W;
   localparam int CNT_W = $clog2(BEATS);
   localparam int OFF_W = offset_bits(LINE_W);
   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

   state_t                state;
   logic [NUM_PORTS-1:0]  grant_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [LINE_W-1:0]     wdata_q;
   logic [LINE_W-1:0]     rbuf;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cnt_inc;

   logic [NUM_PORTS-1:0]  req_any;
   logic [NUM_PORTS-1:0]  arb_grant;
   logic [IDX_W-1:0]      arb_idx;
   logic                  arb_valid;
   logic [ADDR_W-1:0]     sel_addr;
   logic [LINE_W-1:0]     sel_wdata;
   op_t                   sel_op;
   logic [LINE_W-1:0]     next_buf;

   assign req_any     = cache_read | cache_write;
   assign cnt_inc     = cnt + CNT_W'(1);
   assign cache_raddr = addr_q;
   assign bmem_addr   = addr_q;
   assign dbg_state   = state;

   cacheline_rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .en          (state == IDLE),
      .req         (req_any),
      .grant       (arb_grant),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   // Winner's request fields, and the read buffer with the incoming beat merged in.
   always_comb begin
      sel_addr  = cache_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
      sel_wdata = cache_wdata[int'(arb_idx)*LINE_W +: LINE_W];
      sel_op    = cache_write[arb_idx] ? OP_WRITE : OP_READ;
      next_buf  = rbuf;
      next_buf[int'(cnt)*BEAT_W +: BEAT_W] = bmem_rdata;
   end

   // Transaction FSM with registered memory-side and response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         grant_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rbuf        <= '0;
         cnt         <= '0;
         cache_rdata <= '0;
         cache_resp  <= '0;
         bmem_read   <= 1'b0;
         bmem_write  <= 1'b0;
         bmem_wdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               cache_resp <= '0;
               if (arb_valid) begin
                  grant_q <= arb_grant;
                  addr_q  <= sel_addr & ALIGN_MASK;
                  wdata_q <= sel_wdata;
                  cnt     <= '0;
                  if (sel_op == OP_WRITE) begin
                     state      <= WRITE_BURST;
                     bmem_write <= 1'b1;
                     bmem_wdata <= sel_wdata[BEAT_W-1:0];
                  end else begin
                     state     <= READ_REQ;
                     bmem_read <= 1'b1;
                  end
               end
            end
            READ_REQ: begin
               if (bmem_ready) begin
                  bmem_read <= 1'b0;
                  state     <= READ_BURST;
               end
            end
            READ_BURST: begin
               if (bmem_rvalid && (bmem_raddr == addr_q)) begin
                  rbuf <= next_buf;
                  cnt  <= cnt_inc;
                  if (cnt == LAST_BEAT) begin
                     cache_rdata <= next_buf;
                     cache_resp  <= grant_q;
                     state       <= RESP;
                  end
               end
            end
            WRITE_BURST: begin
               if (bmem_ready) begin
                  cnt <= cnt_inc;
                  if (cnt == LAST_BEAT) begin
                     bmem_write <= 1'b0;
                     bmem_wdata <= '0;
                     cache_resp <= grant_q;
                     state      <= RESP;
                  end else begin
                     bmem_wdata <= wdata_q[int'(cnt_inc)*BEAT_W +: BEAT_W];
                  end
               end
            end
            RESP: begin
               cache_resp <= '0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cacheline_arb_adapter.sv
// Self-checking bench for cacheline_arb_adapter (default parameters).
module tb_cacheline_arb_adapter;
   import cacheline_arb_pkg::*;

   localparam int NUM_PORTS = 2;
   localparam int ADDR_W    = 32;
   localparam int LINE_W    = 256;
   localparam int BEAT_W    = 64;
   localparam int BEATS     = LINE_W / BEAT_W;

   logic                        clk = 1'b0;
   logic                        rst;
   logic [NUM_PORTS*ADDR_W-1:0] cache_addr;
   logic [NUM_PORTS-1:0]        cache_read;
   logic [NUM_PORTS-1:0]        cache_write;
   logic [NUM_PORTS*LINE_W-1:0] cache_wdata;
   logic [LINE_W-1:0]           cache_rdata;
   logic [ADDR_W-1:0]           cache_raddr;
   logic [NUM_PORTS-1:0]        cache_resp;
   logic [ADDR_W-1:0]           bmem_addr;
   logic                        bmem_read;
   logic                        bmem_write;
   logic [BEAT_W-1:0]           bmem_wdata;
   logic                        bmem_ready;
   logic [BEAT_W-1:0]           bmem_rdata;
   logic [ADDR_W-1:0]           bmem_raddr;
   logic                        bmem_rvalid;
   state_t                      dbg_state;

   int checks = 0;
   int errors = 0;

   logic [LINE_W-1:0] exp_q[$];
   logic [BEAT_W-1:0] beat_q[$];

   cacheline_arb_adapter #(
      .NUM_PORTS (NUM_PORTS), .ADDR_W (ADDR_W), .LINE_W (LINE_W), .BEAT_W (BEAT_W)
   ) dut (
      .clk (clk), .rst (rst),
      .cache_addr (cache_addr), .cache_read (cache_read), .cache_write (cache_write),
      .cache_wdata (cache_wdata), .cache_rdata (cache_rdata), .cache_raddr (cache_raddr),
      .cache_resp (cache_resp), .bmem_addr (bmem_addr), .bmem_read (bmem_read),
      .bmem_write (bmem_write), .bmem_wdata (bmem_wdata), .bmem_ready (bmem_ready),
      .bmem_rdata (bmem_rdata), .bmem_raddr (bmem_raddr), .bmem_rvalid (bmem_rvalid),
      .dbg_state (dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic set_port(input int p, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] w);
      cache_addr[p*ADDR_W +: ADDR_W]  = a;
      cache_wdata[p*LINE_W +: LINE_W] = w;
   endtask

   // Memory responder for one read: accepts the command after ready_low
   // stalled cycles (offering junk rvalid meanwhile), then returns the beats
   // in order with an optional stray beat before beat stray_after.
   task automatic serve_read(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] line,
                             input int ready_low, input int stray_after,
                             output int rd_cycles, output bit seen);
      int wait_n;
      wait_n    = 0;
      rd_cycles = 0;
      seen      = 1'b0;
      while (!bmem_read && wait_n < 20) begin
         tick();
         wait_n++;
      end
      seen = bmem_read;
      while (bmem_read && rd_cycles < 20) begin
         rd_cycles++;
         bmem_ready  = (rd_cycles > ready_low);
         bmem_rvalid = 1'b1;
         bmem_raddr  = a;
         bmem_rdata  = {$urandom, $urandom};
         tick();
      end
      for (int i = 0; i < BEATS; i++) begin
         if (i == stray_after) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h2000_0000;
            bmem_rdata  = {$urandom, $urandom};
            tick();
         end
         bmem_rvalid = 1'b1;
         bmem_raddr  = a;
         bmem_rdata  = line[i*BEAT_W +: BEAT_W];
         tick();
      end
      bmem_rvalid = 1'b0;
      bmem_ready  = 1'b1;
   endtask

   // ---------------- test tasks ----------------
   task automatic test_reset();
      repeat (3) tick();
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
      checks++; if (cache_resp !== '0) begin errors++; $display("FAIL reset_resp: got %b expected 0", cache_resp); end
      checks++; if (cache_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", cache_rdata); end
      checks++; if (bmem_addr !== '0 || cache_raddr !== '0) begin errors++; $display("FAIL reset_addr: got %h/%h expected 0", bmem_addr, cache_raddr); end
      checks++; if ({bmem_read, bmem_write} !== 2'b00 || bmem_wdata !== '0) begin errors++; $display("FAIL reset_bmem: got rd=%b wr=%b wd=%h expected 0", bmem_read, bmem_write, bmem_wdata); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_read_stray();
      logic [LINE_W-1:0] line;
      int rdc;
      bit seen;
      line = rand_line();
      exp_q.push_back(line);
      set_port(0, 32'h1000_0024, '0);
      cache_read = 2'b01;
      tick();
      checks++; if (bmem_read !== 1'b1 || bmem_addr !== 32'h1000_0020) begin errors++; $display("FAIL read_cmd: got rd=%b addr=%h expected 1/10000020", bmem_read, bmem_addr); end
      serve_read(32'h1000_0020, line, 0, 2, rdc, seen);
      checks++; if (cache_resp !== 2'b01) begin errors++; $display("FAIL read_resp: got %b expected 01", cache_resp); end
      checks++; if (cache_rdata !== exp_q.pop_front()) begin errors++; $display("FAIL read_rdata: got %h expected %h", cache_rdata, line); end
      checks++; if (cache_raddr !== 32'h1000_0020) begin errors++; $display("FAIL read_raddr: got %h expected 10000020", cache_raddr); end
      cache_read = '0;
      tick();
      checks++; if (cache_resp !== 2'b00) begin errors++; $display("FAIL read_resp_pulse: got %b expected 00", cache_resp); end
   endtask

   // Write of one line from port p; both=1 also asserts read on that port.
   task automatic test_write(input int p, input bit both, input logic [ADDR_W-1:0] a,
                             input int stall_cyc, input int exp_resp_cyc);
      logic [LINE_W-1:0]    w;
      logic [BEAT_W-1:0]    eb;
      logic [NUM_PORTS-1:0] er;
      int  resp_cyc;
      bit  saw_read;
      w = rand_line();
      for (int i = 0; i < BEATS; i++) beat_q.push_back(w[i*BEAT_W +: BEAT_W]);
      er = '0;
      er[p] = 1'b1;
      set_port(p, a, w);
      cache_write[p] = 1'b1;
      if (both) cache_read[p] = 1'b1;
      bmem_ready = 1'b1;
      resp_cyc = -1;
      saw_read = 1'b0;
      for (int cyc = 1; cyc <= 15 && resp_cyc < 0; cyc++) begin
         tick();
         if (bmem_read) saw_read = 1'b1;
         if (cache_resp !== '0) begin
            resp_cyc = cyc;
         end else begin
            bmem_ready = (cyc != stall_cyc);
            if (bmem_write && bmem_ready) begin
               eb = (beat_q.size() > 0) ? beat_q.pop_front() : 'x;
               checks++; if (bmem_wdata !== eb) begin errors++; $display("FAIL write_beat: got %h expected %h at cycle %0d", bmem_wdata, eb, cyc); end
            end
         end
      end
      checks++; if (resp_cyc != exp_resp_cyc) begin errors++; $display("FAIL write_latency: got %0d expected %0d", resp_cyc, exp_resp_cyc); end
      checks++; if (cache_resp !== er) begin errors++; $display("FAIL write_resp: got %b expected %b", cache_resp, er); end
      checks++; if (cache_raddr !== (a & ~32'h1f)) begin errors++; $display("FAIL write_raddr: got %h expected %h", cache_raddr, a & ~32'h1f); end
      checks++; if (bmem_write !== 1'b0 || bmem_wdata !== '0) begin errors++; $display("FAIL write_idle_out: got wr=%b wd=%h expected 0", bmem_write, bmem_wdata); end
      checks++; if (beat_q.size() != 0) begin errors++; $display("FAIL write_beats_left: got %0d expected 0", beat_q.size()); end
      checks++; if (saw_read !== 1'b0) begin errors++; $display("FAIL write_no_read: got %b expected 0", saw_read); end
      beat_q.delete();
      cache_write = '0;
      cache_read  = '0;
      tick();
      checks++; if (cache_resp !== '0) begin errors++; $display("FAIL write_resp_pulse: got %b expected 0", cache_resp); end
   endtask

   task automatic test_read_ready_stall();
      logic [LINE_W-1:0] line;
      int rdc;
      bit seen;
      line = rand_line();
      exp_q.push_back(line);
      set_port(1, 32'h0000_0510, '0);
      cache_read = 2'b10;
      serve_read(32'h0000_0500, line, 3, -1, rdc, seen);
      checks++; if (seen !== 1'b1 || rdc != 4) begin errors++; $display("FAIL stall_read_cycles: got seen=%b cycles=%0d expected 1/4", seen, rdc); end
      checks++; if (cache_resp !== 2'b10) begin errors++; $display("FAIL stall_resp: got %b expected 10", cache_resp); end
      checks++; if (cache_rdata !== exp_q.pop_front()) begin errors++; $display("FAIL stall_rdata: got %h expected %h", cache_rdata, line); end
      cache_read = '0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [LINE_W-1:0]    l0, l1, el;
      logic [NUM_PORTS-1:0] er;
      logic [ADDR_W-1:0]    ea;
      int p, rdc;
      bit seen;
      l0 = rand_line();
      l1 = rand_line();
      set_port(0, 32'h0000_0100, '0);
      set_port(1, 32'h0000_0200, '0);
      cache_read = 2'b11;
      for (int k = 0; k < 4; k++) begin
`ifdef CACHELINE_ARB_RR_EN
         p = k % 2;
`else
         p = 0;
`endif
         el = (p == 0) ? l0 : l1;
         ea = (p == 0) ? 32'h0000_0100 : 32'h0000_0200;
         er = '0;
         er[p] = 1'b1;
         exp_q.push_back(el);
         serve_read(ea, el, 0, -1, rdc, seen);
         checks++; if (seen !== 1'b1) begin errors++; $display("FAIL b2b_cmd[%0d]: got %b expected 1", k, seen); end
         checks++; if (cache_resp !== er) begin errors++; $display("FAIL b2b_grant[%0d]: got %b expected %b", k, cache_resp, er); end
         checks++; if (cache_rdata !== exp_q.pop_front() || cache_raddr !== ea) begin errors++; $display("FAIL b2b_data[%0d]: got %h@%h expected %h@%h", k, cache_rdata, cache_raddr, el, ea); end
         tick();
         checks++; if (dbg_state !== IDLE || cache_resp !== '0) begin errors++; $display("FAIL b2b_idle[%0d]: got state=%0d resp=%b expected IDLE/0", k, dbg_state, cache_resp); end
      end
      cache_read = '0;
      tick();
   endtask

   task automatic test_reset_mid_burst();
      logic [LINE_W-1:0] line, fresh;
      int rdc;
      bit seen;
      line  = rand_line();
      fresh = rand_line();
      set_port(0, 32'h0000_0300, '0);
      cache_read = 2'b01;
      bmem_ready = 1'b1;
      tick();
      tick();
      checks++; if (dbg_state !== READ_BURST) begin errors++; $display("FAIL mid_state: got %0d expected %0d", dbg_state, READ_BURST); end
      for (int i = 0; i < 2; i++) begin
         bmem_rvalid = 1'b1;
         bmem_raddr  = 32'h0000_0300;
         bmem_rdata  = line[i*BEAT_W +: BEAT_W];
         tick();
      end
      bmem_rvalid = 1'b0;
      cache_read  = '0;
      rst = 1'b1;
      tick();
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL mid_rst_state: got %0d expected %0d", dbg_state, IDLE); end
      checks++; if (cache_resp !== '0 || cache_rdata !== '0 || cache_raddr !== '0) begin errors++; $display("FAIL mid_rst_cache_out: got resp=%b raddr=%h rdata=%h expected 0", cache_resp, cache_raddr, cache_rdata); end
      checks++; if (bmem_addr !== '0 || bmem_read !== 1'b0 || bmem_write !== 1'b0 || bmem_wdata !== '0) begin errors++; $display("FAIL mid_rst_bmem_out: got addr=%h rd=%b wr=%b expected 0", bmem_addr, bmem_read, bmem_write); end
      rst = 1'b0;
      tick();
      checks++; if (cache_resp !== '0) begin errors++; $display("FAIL mid_rst_no_resp: got %b expected 0", cache_resp); end
      exp_q.push_back(fresh);
      set_port(0, 32'h0000_0340, '0);
      cache_read = 2'b01;
      serve_read(32'h0000_0340, fresh, 0, -1, rdc, seen);
      checks++; if (cache_resp !== 2'b01) begin errors++; $display("FAIL fresh_resp: got %b expected 01", cache_resp); end
      checks++; if (cache_rdata !== exp_q.pop_front()) begin errors++; $display("FAIL fresh_rdata: got %h expected %h", cache_rdata, fresh); end
      cache_read = '0;
      tick();
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      rst         = 1'b1;
      cache_addr  = '0;
      cache_read  = '0;
      cache_write = '0;
      cache_wdata = '0;
      bmem_ready  = 1'b1;
      bmem_rdata  = '0;
      bmem_raddr  = '0;
      bmem_rvalid = 1'b0;
      test_reset();
      test_read_stray();
      test_write(1, 1'b0, 32'h0000_0040, 2, 6);
      test_write(0, 1'b1, 32'h0000_0080, -1, 5);
      test_read_ready_stall();
      test_back_to_back();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
